// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// RUN/HALT controller that stops fetching when the halt encoding is seen.
//
//   state | meaning
//   RUN   | fetching; redirect > stall > advance each edge
//   HALT  | halt word fetched; PC frozen, IF/ID bubble, only reset exits
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemData,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectTarget,
  output logic [31:0] pcOutIF,
  output logic [31:0] instrID,
  output logic [31:0] pcPlus4ID,
  output logic        validID,
  output logic        halted,
  output logic [15:0] fetchCount
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;
  logic [31:0] pc_plus4;

  // Targets are word aligned, so the low two bits never reach the PC.
  logic unused_tgt_bits;
  assign unused_tgt_bits = ^redirectTarget[1:0];

  assign pc_plus4 = pc_q + 32'd4;

  // Next-state logic: hold by default, then apply the per-state rules.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
    case (state_q)
      RUN: begin
        if (redirect) begin
          pc_d    = {redirectTarget[31:2], 2'b00};
          instr_d = 32'd0;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
        end else if (stall) begin
          // everything holds
        end else if (imemData == HALT_WORD) begin
          state_d = HALT;
          instr_d = 32'd0;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
        end else begin
          pc_d    = pc_plus4;
          instr_d = imemData;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
        end
      end
      HALT: begin
        instr_d = 32'd0;
        pc4_d   = 32'd0;
        valid_d = 1'b0;
      end
      default: state_d = RUN;
    endcase
  end

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign imemAddr   = pc_q;
  assign pcOutIF    = pc_q;
  assign instrID    = instr_q;
  assign pcPlus4ID  = pc4_q;
  assign validID    = valid_q;
  assign halted     = (state_q == HALT);
  assign fetchCount = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: vector table plus a long saturation run.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectTarget;
  logic [31:0] pcOutIF;
  logic [31:0] instrID;
  logic [31:0] pcPlus4ID;
  logic        validID;
  logic        halted;
  logic [15:0] fetchCount;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .imemAddr(imemAddr), .imemData(imemData),
    .stall(stall), .redirect(redirect), .redirectTarget(redirectTarget),
    .pcOutIF(pcOutIF), .instrID(instrID), .pcPlus4ID(pcPlus4ID),
    .validID(validID), .halted(halted), .fetchCount(fetchCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
    logic [15:0] count;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
    logic [15:0] count;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[19];

  function automatic vec_t mk(input logic r, input logic s, input logic rd,
                              input logic [31:0] t, input logic [31:0] d,
                              input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] p4, input logic v,
                              input logic h, input logic [15:0] c);
    vec_t x;
    x.rst_n = r; x.stall = s; x.redirect = rd; x.target = t; x.data = d;
    x.pc = pc; x.instr = ins; x.pc4 = p4; x.valid = v; x.halted = h; x.count = c;
    return x;
  endfunction

  task automatic cmp32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, push its expectation, and compare after the edge.
  task automatic step(input vec_t v, input string tag);
    exp_t e, got;
    rst_n = v.rst_n; stall = v.stall; redirect = v.redirect;
    redirectTarget = v.target; imemData = v.data;
    e.pc = v.pc; e.instr = v.instr; e.pc4 = v.pc4;
    e.valid = v.valid; e.halted = v.halted; e.count = v.count;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    cmp32({tag, " pcOutIF"},    pcOutIF,           got.pc);
    cmp32({tag, " imemAddr"},   imemAddr,          got.pc);
    cmp32({tag, " instrID"},    instrID,           got.instr);
    cmp32({tag, " pcPlus4ID"},  pcPlus4ID,         got.pc4);
    cmp32({tag, " validID"},    {31'd0, validID},  {31'd0, got.valid});
    cmp32({tag, " halted"},     {31'd0, halted},   {31'd0, got.halted});
    cmp32({tag, " fetchCount"}, {16'd0, fetchCount}, {16'd0, got.count});
  endtask

  initial begin
    logic [31:0] m_pc;
    logic [15:0] m_cnt;
    logic [31:0] d;
    vec_t v;

    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirectTarget = 32'd0; imemData = 32'd0;

    //              rst s  rd target        data           pc             instr          pc4            v  h  count
    vecs[0]  = mk(0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         0, 0, 16'd0);
    vecs[1]  = mk(1, 0, 0, 32'h0,         32'h20100001,  32'h4,         32'h20100001,  32'h4,         1, 0, 16'd1);
    vecs[2]  = mk(1, 0, 0, 32'h0,         32'h20110002,  32'h8,         32'h20110002,  32'h8,         1, 0, 16'd2);
    vecs[3]  = mk(1, 1, 0, 32'h0,         32'h02119020,  32'h8,         32'h20110002,  32'h8,         1, 0, 16'd2);
    vecs[4]  = mk(1, 1, 0, 32'h0,         32'h02119020,  32'h8,         32'h20110002,  32'h8,         1, 0, 16'd2);
    vecs[5]  = mk(1, 0, 0, 32'h0,         32'h02119020,  32'hC,         32'h02119020,  32'hC,         1, 0, 16'd3);
    vecs[6]  = mk(1, 1, 1, 32'h43,        32'h11111111,  32'h40,        32'h0,         32'h0,         0, 0, 16'd3);
    vecs[7]  = mk(1, 0, 0, 32'h0,         32'h22222222,  32'h44,        32'h22222222,  32'h44,        1, 0, 16'd4);
    vecs[8]  = mk(1, 0, 1, 32'h100,       32'hFFFFFFFF,  32'h100,       32'h0,         32'h0,         0, 0, 16'd4);
    vecs[9]  = mk(1, 1, 0, 32'h0,         32'hFFFFFFFF,  32'h100,       32'h0,         32'h0,         0, 0, 16'd4);
    vecs[10] = mk(1, 0, 1, 32'h10,        32'h0,         32'h10,        32'h0,         32'h0,         0, 0, 16'd4);
    vecs[11] = mk(1, 0, 0, 32'h0,         32'hFFFFFFFF,  32'h10,        32'h0,         32'h0,         0, 1, 16'd4);
    vecs[12] = mk(1, 0, 1, 32'h0,         32'h1,         32'h10,        32'h0,         32'h0,         0, 1, 16'd4);
    vecs[13] = mk(1, 0, 0, 32'h0,         32'h33333333,  32'h10,        32'h0,         32'h0,         0, 1, 16'd4);
    vecs[14] = mk(0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         0, 0, 16'd0);
    vecs[15] = mk(1, 0, 0, 32'h0,         32'h44,        32'h4,         32'h44,        32'h4,         1, 0, 16'd1);
    vecs[16] = mk(0, 1, 1, 32'h80,        32'h0,         32'h0,         32'h0,         32'h0,         0, 0, 16'd0);
    vecs[17] = mk(1, 0, 1, 32'hFFFFFFFF,  32'h0,         32'hFFFFFFFC,  32'h0,         32'h0,         0, 0, 16'd0);
    vecs[18] = mk(1, 0, 0, 32'h0,         32'h55,        32'h0,         32'h55,        32'h0,         1, 0, 16'd1);

    @(negedge clk);
    for (int i = 0; i < 19; i++) step(vecs[i], $sformatf("vec%0d", i));

    // Long advance run: count must climb to 0xFFFF and then stick there.
    m_pc  = 32'h0;
    m_cnt = 16'd1;
    for (int i = 0; i < 65540; i++) begin
      d = {16'hA5A5, i[15:0]};
      m_pc  = m_pc + 32'd4;
      m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
      if (m_cnt >= 16'hFFFD || i < 3) begin
        v = mk(1, 0, 0, 32'h0, d, m_pc, d, m_pc, 1, 0, m_cnt);
        step(v, $sformatf("sat%0d", i));
      end else begin
        rst_n = 1'b1; stall = 1'b0; redirect = 1'b0; imemData = d;
        @(posedge clk);
        #1;
      end
    end

    // Saturated counter survives a stall and still holds after a halt.
    v = mk(1, 1, 0, 32'h0, 32'h0, m_pc, {16'hA5A5, 16'd3}, m_pc, 1, 0, 16'hFFFF);
    step(v, "sat_stall");
    v = mk(1, 0, 0, 32'h0, 32'hFFFFFFFF, m_pc, 32'h0, 32'h0, 0, 1, 16'hFFFF);
    step(v, "sat_halt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter HALT_WORD, default 32'hFFFF_FFFF, instruction encoding that stops fetch.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 imemAddr  output  32  instruction-memory address; combinationally equal to the current PC.
REQ-006 imemData  input  32  instruction word returned combinationally by instruction memory for imemAddr.
REQ-007 stall  input  1  load-use stall request from the hazard unit; hold PC and IF/ID.
REQ-008 redirect  input  1  taken branch or jump resolved in ID; load redirectTarget and flush IF/ID.
REQ-009 redirectTarget  input  32  new PC when redirect is 1.
REQ-010 pcOutIF  output  32  current PC register.
REQ-011 instrID  output  32  IF/ID instruction register.
REQ-012 pcPlus4ID  output  32  IF/ID PC+4 register.
REQ-013 validID  output  1  IF/ID entry holds a real instruction; 0 = bubble.
REQ-014 halted  output  1  fetch has stopped on HALT_WORD.
REQ-015 fetchCount  output  16  number of instructions written into IF/ID with validID=1.

Function
REQ-016 State machine has two states: RUN and HALT; halted SHALL be 1 exactly in HALT.
REQ-017 In RUN, per edge, priority SHALL be redirect > stall > normal advance.
REQ-018 Redirect: PC <= {redirectTarget[31:2],2'b00}; instrID <= 0; pcPlus4ID <= 0; validID <= 0; fetchCount unchanged; state stays RUN.
REQ-019 Stall (redirect=0): PC, instrID, pcPlus4ID, validID, fetchCount all hold.
REQ-020 Normal advance, imemData != HALT_WORD: PC <= PC+4 (mod 2^32, 0xFFFF_FFFC wraps to 0x0000_0000); instrID <= imemData; pcPlus4ID <= PC+4; validID <= 1; fetchCount increments.
REQ-021 Normal advance, imemData == HALT_WORD: state <= HALT; PC holds; instrID <= 0; pcPlus4ID <= 0; validID <= 0; fetchCount unchanged.
REQ-022 HALT_WORD present while redirect=1 or stall=1 SHALL NOT enter HALT (redirect/stall rules apply).
REQ-023 In HALT: PC, fetchCount hold; IF/ID SHALL present bubble (instrID 0, validID 0); stall and redirect ignored; exit only via reset.
REQ-024 fetchCount SHALL saturate at 16'hFFFF, no wrap.
REQ-025 Latency: an instruction at PC appears on instrID one edge after it is presented on imemData with no stall/redirect.
REQ-026 Outputs SHALL be glitch-free registered values except imemAddr (combinational from PC register).

Reset
REQ-027 On a rising edge with rst_n=0: PC <= RESET_PC, instrID <= 0, pcPlus4ID <= 0, validID <= 0, fetchCount <= 0, state <= RUN, halted <= 0.
REQ-028 Reset SHALL override stall, redirect and HALT; reset asserted mid-stall or in HALT yields the REQ-027 values on the next edge.
REQ-029 rst_n deasserted: first fetch at RESET_PC on the following edge.

Verification
REQ-030 Reset then 3 edges, imem returns 0x20100001,0x20110002,0x02119020 -> pcOutIF 0x0C, instrID 0x02119020, pcPlus4ID 0x0C, fetchCount 3.
REQ-031 Stall held 2 edges at PC 0x08 -> pcOutIF stays 0x08, instrID/fetchCount unchanged; release -> advance resumes at 0x08.
REQ-032 redirect=1, stall=1, redirectTarget 0x0000_0043 -> pcOutIF 0x40, validID 0, instrID 0, fetchCount unchanged.
REQ-033 HALT_WORD at PC 0x10, no stall -> halted 1, pcOutIF 0x10, validID 0; later redirect to 0x00 ignored; rst_n low one edge -> halted 0, pcOutIF RESET_PC.
REQ-034 HALT_WORD with redirect=1 same edge -> halted 0, pcOutIF = target.
REQ-035 Redirect to 0xFFFF_FFFC then one advance -> pcOutIF 0x0000_0000, pcPlus4ID 0x0000_0000; preload fetchCount near 0xFFFF via long run -> saturates at 0xFFFF.
